// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional writeback snoop of held operands is enabled by defining ID_EX_WB_BYPASS_EN.
module id_ex_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned IMM_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              validIn,
    output logic              readyOut,
    input  logic              signExtendRegIn,
    input  logic              writeRegIn,
    input  logic [REG_AW-1:0] rs1In,
    input  logic [REG_AW-1:0] rs2In,
    input  logic [REG_AW-1:0] rdIn,
    input  logic [DATA_W-1:0] data1In,
    input  logic [DATA_W-1:0] data2In,
    input  logic [IMM_W-1:0]  unextendedIn,
    output logic              validOut,
    input  logic              readyIn,
    output logic              signExtendRegOut,
    output logic              writeRegOut,
    output logic [REG_AW-1:0] rs1Out,
    output logic [REG_AW-1:0] rs2Out,
    output logic [REG_AW-1:0] rdOut,
    output logic [DATA_W-1:0] data1Out,
    output logic [DATA_W-1:0] data2Out,
    output logic [IMM_W-1:0]  unextendedOut,
    input  logic              wbWriteIn,
    input  logic [REG_AW-1:0] wbRdIn,
    input  logic [DATA_W-1:0] wbDataIn
);

    typedef struct packed {
        logic              sign_ext;
        logic              write_reg;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [IMM_W-1:0]  imm;
    } entry_t;

    entry_t out_q, skid_q;
    logic   out_valid_q, skid_valid_q;
    entry_t in_raw, in_p, out_p, skid_p;
    logic   acc, drn;

    always_comb begin
        in_raw           = '0;
        in_raw.sign_ext  = signExtendRegIn;
        in_raw.write_reg = writeRegIn;
        in_raw.rs1       = rs1In;
        in_raw.rs2       = rs2In;
        in_raw.rd        = rdIn;
        in_raw.data1     = data1In;
        in_raw.data2     = data2In;
        in_raw.imm       = unextendedIn;
    end

`ifdef ID_EX_WB_BYPASS_EN
    function automatic entry_t snoop(input entry_t e, input logic wr,
                                     input logic [REG_AW-1:0] wrd,
                                     input logic [DATA_W-1:0] wdata);
        entry_t r;
        r = e;
        // Register 0 is hardwired, so a write to it never forwards.
        if (wr && (wrd != '0)) begin
            if (wrd == e.rs1) r.data1 = wdata;
            if (wrd == e.rs2) r.data2 = wdata;
        end
        return r;
    endfunction

    always_comb begin
        in_p   = snoop(in_raw, wbWriteIn, wbRdIn, wbDataIn);
        out_p  = out_valid_q  ? snoop(out_q, wbWriteIn, wbRdIn, wbDataIn)  : out_q;
        skid_p = skid_valid_q ? snoop(skid_q, wbWriteIn, wbRdIn, wbDataIn) : skid_q;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wbWriteIn, wbRdIn, wbDataIn};

    always_comb begin
        in_p   = in_raw;
        out_p  = out_q;
        skid_p = skid_q;
    end
`endif

    assign readyOut = ~skid_valid_q;
    assign acc      = validIn & readyOut;
    assign drn      = out_valid_q & readyIn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || drn) begin
            if (skid_valid_q) begin
                out_q        <= skid_p;
                out_valid_q  <= 1'b1;
                skid_valid_q <= acc;
                if (acc) skid_q <= in_p;
            end else begin
                out_valid_q <= acc;
                if (acc) out_q <= in_p;
            end
        end else begin
            // OUT is stalled: hold it and park any new entry in SKID.
            out_q <= out_p;
            if (acc) begin
                skid_q       <= in_p;
                skid_valid_q <= 1'b1;
            end else begin
                skid_q <= skid_p;
            end
        end
    end

    assign validOut         = out_valid_q;
    assign signExtendRegOut = out_q.sign_ext;
    assign writeRegOut      = out_q.write_reg;
    assign rs1Out           = out_q.rs1;
    assign rs2Out           = out_q.rs2;
    assign rdOut            = out_q.rd;
    assign data1Out         = out_q.data1;
    assign data2Out         = out_q.data2;
    assign unextendedOut    = out_q.imm;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus randomized traffic against a queue model.
// Honors ID_EX_WB_BYPASS_EN the same way as the design.
module tb_id_ex_pipe;
    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int IMM_W  = 3;

    typedef struct packed {
        logic              sign_ext;
        logic              write_reg;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [IMM_W-1:0]  imm;
    } entry_t;

    logic clk = 0;
    logic reset, flush, validIn, readyIn, signExtendRegIn, writeRegIn, wbWriteIn;
    logic [REG_AW-1:0] rs1In, rs2In, rdIn, wbRdIn;
    logic [DATA_W-1:0] data1In, data2In, wbDataIn;
    logic [IMM_W-1:0]  unextendedIn;
    logic readyOut, validOut, signExtendRegOut, writeRegOut;
    logic [REG_AW-1:0] rs1Out, rs2Out, rdOut;
    logic [DATA_W-1:0] data1Out, data2Out;
    logic [IMM_W-1:0]  unextendedOut;

    int checks = 0;
    int errors = 0;

    id_ex_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .validIn(validIn), .readyOut(readyOut),
        .signExtendRegIn(signExtendRegIn), .writeRegIn(writeRegIn),
        .rs1In(rs1In), .rs2In(rs2In), .rdIn(rdIn), .data1In(data1In), .data2In(data2In),
        .unextendedIn(unextendedIn), .validOut(validOut), .readyIn(readyIn),
        .signExtendRegOut(signExtendRegOut), .writeRegOut(writeRegOut),
        .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut), .data1Out(data1Out),
        .data2Out(data2Out), .unextendedOut(unextendedOut),
        .wbWriteIn(wbWriteIn), .wbRdIn(wbRdIn), .wbDataIn(wbDataIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of depth 2; the front entry is what OUT shows.
    entry_t q[$];
    entry_t shown = '0;
    entry_t m_in;
    bit     m_acc, m_drn;

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            q.delete();
            shown = '0;
        end else begin
            m_in = '{signExtendRegIn, writeRegIn, rs1In, rs2In, rdIn, data1In, data2In,
                     unextendedIn};
            m_acc = validIn && (q.size() < 2);
            m_drn = (q.size() > 0) && readyIn;
`ifdef ID_EX_WB_BYPASS_EN
            if (wbWriteIn && wbRdIn != 0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].rs1 == wbRdIn) q[i].data1 = wbDataIn;
                    if (q[i].rs2 == wbRdIn) q[i].data2 = wbDataIn;
                end
                if (m_in.rs1 == wbRdIn) m_in.data1 = wbDataIn;
                if (m_in.rs2 == wbRdIn) m_in.data2 = wbDataIn;
            end
`endif
            if (m_drn) void'(q.pop_front());
            if (m_acc) q.push_back(m_in);
            if (q.size() > 0) shown = q[0];
        end
    end

    always @(negedge clk) begin
        chk("validOut", validOut, q.size() > 0);
        chk("readyOut", readyOut, q.size() < 2);
        chk("payload", {signExtendRegOut, writeRegOut, rs1Out, rs2Out, rdOut, data1Out,
                        data2Out, unextendedOut}, shown);
    end

    task automatic idle_inputs();
        flush = 0; validIn = 0; signExtendRegIn = 0; writeRegIn = 0;
        rs1In = 0; rs2In = 0; rdIn = 0; data1In = 0; data2In = 0; unextendedIn = 0;
        wbWriteIn = 0; wbRdIn = 0; wbDataIn = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [7:0] stream [4];

    initial begin
        idle_inputs();
        readyIn = 0;
        reset = 1;
        step(); step();
        chk("reset_valid", validOut, 1'b0);
        chk("reset_ready", readyOut, 1'b1);
        chk("reset_data1", data1Out, 8'h00);
        #1 reset = 0;

        // Streaming.
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        readyIn = 1;
        for (int i = 0; i < 4; i++) begin
            validIn = 1; data1In = stream[i];
            step();
            chk("stream_data", data1Out, stream[i]);
            chk("stream_valid", validOut, 1'b1);
            chk("stream_ready", readyOut, 1'b1);
            #1;
        end

        // Reset mid-transfer: outputs clear in the same cycle.
        reset = 1;
        #1;
        chk("rst_mid_valid", validOut, 1'b0);
        chk("rst_mid_data", data1Out, 8'h00);
        chk("rst_mid_ready", readyOut, 1'b1);
        step(); #1 reset = 0; validIn = 0;

        // Stall with two entries, then release.
        readyIn = 0; validIn = 1; data1In = 8'h11;
        step(); chk("stall_a", data1Out, 8'h11); chk("stall_rdy_a", readyOut, 1'b1);
        #1 data1In = 8'h22;
        step(); chk("stall_hold", data1Out, 8'h11); chk("stall_full", readyOut, 1'b0);
        #1 validIn = 0; readyIn = 1;
        step(); chk("release_b", data1Out, 8'h22); chk("release_rdy", readyOut, 1'b1);
        #1;
        step(); chk("release_empty", validOut, 1'b0);

        // Flush with occupancy 2 and a same-cycle accept attempt.
        #1 readyIn = 0; validIn = 1; writeRegIn = 1; data1In = 8'h11;
        step(); #1 data1In = 8'h22;
        step(); #1 data1In = 8'h33; flush = 1;
        step();
        chk("flush_valid", validOut, 1'b0);
        chk("flush_wreg", writeRegOut, 1'b0);
        chk("flush_ready", readyOut, 1'b1);
        chk("flush_data", data1Out, 8'h00);
        #1 flush = 0; validIn = 0; writeRegIn = 0; readyIn = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("flush_no_c", validOut, 1'b0); #1;
        end

        // Writeback snoop on a stalled entry.
        readyIn = 0; validIn = 1; rs1In = 3; data1In = 8'h05;
        step(); #1 validIn = 0; wbWriteIn = 1; wbRdIn = 3; wbDataIn = 8'hA7;
        step();
`ifdef ID_EX_WB_BYPASS_EN
        chk("snoop_hit", data1Out, 8'hA7);
`else
        chk("snoop_off", data1Out, 8'h05);
`endif
        #1 wbWriteIn = 0; flush = 1;
        step(); #1 flush = 0; validIn = 1; rs1In = 0; data1In = 8'h05;
        step(); #1 validIn = 0; wbWriteIn = 1; wbRdIn = 0; wbDataIn = 8'hA7;
        step(); chk("snoop_r0", data1Out, 8'h05);
        #1 idle_inputs(); readyIn = 1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(299) == 0);
            flush           = ($urandom_range(15) == 0);
            validIn         = $urandom_range(1);
            readyIn         = ($urandom_range(3) != 0);
            signExtendRegIn = $urandom_range(1);
            writeRegIn      = $urandom_range(1);
            rs1In           = REG_AW'($urandom);
            rs2In           = REG_AW'($urandom);
            rdIn            = REG_AW'($urandom);
            data1In         = DATA_W'($urandom);
            data2In         = DATA_W'($urandom);
            unextendedIn    = IMM_W'($urandom);
            wbWriteIn       = $urandom_range(1);
            wbRdIn          = REG_AW'($urandom);
            wbDataIn        = DATA_W'($urandom);
            step();
            #1;
        end
        reset = 0;
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
